// File: rtl/log_drain_pkg.sv
// log_drain_pkg: shared widths and FSM encoding for the logger drain engine.
package log_drain_pkg;
  localparam int ENTRY_W = 38;
  localparam int ADDR_W = 16;
  typedef logic [ENTRY_W-1:0] entry_t;
  typedef logic [ADDR_W-1:0] addr_t;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;
endpackage

// File: rtl/log_drain_ctr.sv
// log_drain_ctr: entry index with terminal flag and saturating delivery count.
module log_drain_ctr
  import log_drain_pkg::*;
#(
  parameter int LOG_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              step,
  output logic [ADDR_W-1:0] idx,
  output logic              last,
  output logic [ADDR_W-1:0] count
);
  assign last = idx == ADDR_W'(LOG_DEPTH - 1);
  // idx parks on the terminal entry so a drain never wraps back to address 0
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      idx   <= '0;
      count <= '0;
    end else if (clr) begin
      idx   <= '0;
      count <= '0;
    end else if (step) begin
      idx   <= last ? idx : idx + 1'b1;
      count <= &count ? count : count + 1'b1;
    end
endmodule

// File: rtl/log_drain.sv
// log_drain: walks the logger RAM, streams non-empty entries downstream,
// then optionally strobes a RAM clear.
module log_drain
  import log_drain_pkg::*;
#(
  parameter int LOG_DEPTH     = 16,
  parameter bit CLEAR_ON_DONE = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  output logic               re,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [ENTRY_W-1:0] rd_data,
  output logic               clr_ram,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ENTRY_W-1:0] out_data,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  count
);
  logic [2:0] state, next;
  logic       last, xfer, live;

  assign live      = state == S_READ || state == S_CAPT || state == S_SEND;
  assign xfer      = state == S_SEND && out_ready && !abort;
  assign re        = state == S_READ;
  assign clr_ram   = state == S_CLEAR && CLEAR_ON_DONE;
  assign out_valid = state == S_SEND;
  assign busy      = state != S_IDLE;
  assign done      = state == S_FIN;

  always_comb begin
    next = state;
    case (state)
      S_IDLE:  next = start ? S_READ : S_IDLE;
      S_READ:  next = S_CAPT;
      S_CAPT:  next = rd_data == '0 ? S_CLEAR : S_SEND;
      S_SEND:  next = out_ready ? (last ? S_CLEAR : S_READ) : S_SEND;
      S_CLEAR: next = S_FIN;
      default: next = S_IDLE;
    endcase
    if (live && abort) next = S_FIN;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= S_IDLE;
      out_data <= '0;
    end else begin
      state <= next;
      if (state == S_CAPT) out_data <= rd_data;
    end

  log_drain_ctr #(.LOG_DEPTH(LOG_DEPTH)) u_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state == S_IDLE && start),
    .step    (xfer),
    .idx     (rd_addr),
    .last    (last),
    .count   (count)
  );
endmodule

// File: tb/tb_log_drain.sv
// tb_log_drain: directed checks of the drain engine against a simple logger RAM.
module tb_log_drain;
  logic        clk = 0, reset_n = 0;
  logic        start = 0, abort = 0, out_ready = 1, start2 = 0;
  logic        re, clr_ram, out_valid, busy, done;
  logic [15:0] rd_addr, count;
  logic [37:0] rd_data = '0, out_data;
  logic        re2, clr2, ov2, busy2, done2;
  logic [15:0] addr2, count2;
  logic [37:0] rd_data2 = '0, od2;
  logic [37:0] mem [4];
  logic [37:0] mem2 = 38'h5;
  logic [37:0] xq[$];
  logic [15:0] aq[$];
  int          xc[$];
  int          cyc = 0, clr_n = 0, clr_cyc = 0, done_n = 0, done_cyc = 0, both = 0;
  int          x2 = 0, clr2_n = 0, done2_n = 0;
  logic [37:0] last2 = '0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  log_drain #(.LOG_DEPTH(4), .CLEAR_ON_DONE(1)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .re(re),
    .rd_addr(rd_addr), .rd_data(rd_data), .clr_ram(clr_ram), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done), .count(count));

  log_drain #(.LOG_DEPTH(1), .CLEAR_ON_DONE(0)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start2), .abort(1'b0), .re(re2),
    .rd_addr(addr2), .rd_data(rd_data2), .clr_ram(clr2), .out_valid(ov2),
    .out_ready(1'b1), .out_data(od2), .busy(busy2), .done(done2), .count(count2));

  always @(posedge clk) begin
    cyc++;
    if (re) begin aq.push_back(rd_addr); rd_data <= mem[rd_addr[1:0]]; end
    if (out_valid && out_ready && !abort) begin xq.push_back(out_data); xc.push_back(cyc); end
    if (clr_ram) begin clr_n++; clr_cyc = cyc; end
    if (done) begin done_n++; done_cyc = cyc; end
    if (re && clr_ram) both++;
    if (re2) rd_data2 <= mem2;
    if (ov2) begin x2++; last2 = od2; end
    if (clr2) clr2_n++;
    if (done2) done2_n++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    xq.delete(); aq.delete(); xc.delete();
    clr_n = 0; done_n = 0;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 200 && !done; k++) tick();
    if (!done) chk({tag, "_timeout"}, 0, 1);
    tick();
  endtask

  initial begin
    int n;
    logic [37:0] d0;
    logic stable;
    mem[0] = 38'h1; mem[1] = 38'h2; mem[2] = 38'h3; mem[3] = 38'h4;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {re, clr_ram, out_valid, done}, 0);
    chk("rst_count", count, 0);
    chk("rst_data", out_data, 0);
    tick(); reset_n = 1; tick();

    // basic four-entry drain
    abort = 1; tick(); abort = 0;
    chk("idle_abort", busy, 0);
    clear_log(); pulse_start(); wait_done("s1");
    chk("s1_nx", xq.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("s1_x%0d", i), xq[i], 38'(i + 1));
    for (int i = 0; i < 4; i++) chk($sformatf("s1_a%0d", i), aq[i], 16'(i));
    chk("s1_na", aq.size(), 4);
    chk("s1_lat", xc[1] - xc[0], 3);
    chk("s1_count", count, 4);
    chk("s1_clr", clr_n, 1);
    chk("s1_done_gap", done_cyc - clr_cyc, 1);
    chk("s1_done_n", done_n, 1);
    chk("s1_idle", busy, 0);

    // empty slot ends the drain early
    mem[0] = 38'hA; mem[1] = 38'hB; mem[2] = 38'h0; mem[3] = 38'h7;
    clear_log(); pulse_start(); wait_done("s2");
    chk("s2_nx", xq.size(), 2);
    chk("s2_x0", xq[0], 38'hA);
    chk("s2_x1", xq[1], 38'hB);
    chk("s2_na", aq.size(), 3);
    chk("s2_a2", aq[2], 2);
    chk("s2_count", count, 2);
    chk("s2_clr", clr_n, 1);
    chk("s2_hold", count, 2);

    // backpressure holds the entry
    mem[0] = 38'h3F_FFFF_FFFF; mem[1] = 38'h0;
    out_ready = 0; clear_log(); pulse_start();
    for (n = 0; n < 20 && !out_valid; n++) tick();
    chk("s3_valid", out_valid, 1);
    d0 = out_data; n = aq.size(); stable = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      stable &= out_valid && out_data === 38'h3F_FFFF_FFFF;
    end
    chk("s3_d0", d0, 38'h3F_FFFF_FFFF);
    chk("s3_stable", stable, 1);
    chk("s3_no_re", aq.size(), n);
    chk("s3_nx_held", xq.size(), 0);
    out_ready = 1; wait_done("s3");
    chk("s3_nx", xq.size(), 1);
    chk("s3_count", count, 1);

    // abort beats out_ready while entry 1 is offered
    mem[0] = 38'h1; mem[1] = 38'h2; mem[2] = 38'h3; mem[3] = 38'h4;
    clear_log(); pulse_start();
    for (n = 0; n < 30 && !(out_valid && out_data == 38'h2); n++) tick();
    chk("s4_at_e1", out_valid && out_data == 38'h2, 1);
    abort = 1; start = 1; tick(); abort = 0; start = 0;
    chk("s4_done", done, 1);
    chk("s4_valid_drop", out_valid, 0);
    tick();
    chk("s4_busy", busy, 0);
    chk("s4_count", count, 1);
    chk("s4_nx", xq.size(), 1);
    chk("s4_clr", clr_n, 0);
    chk("s4_done_n", done_n, 1);
    tick(3);
    chk("s4_no_restart", busy, 0);

    // asynchronous reset in READ
    clear_log(); pulse_start();
    chk("s5_in_read", re, 1);
    #2 reset_n = 0; #1;
    chk("s5_rst_outs", {re, clr_ram, out_valid, busy, done}, 0);
    chk("s5_rst_data", out_data, 0);
    chk("s5_rst_count", count, 0);
    tick(); reset_n = 1; tick(2);
    chk("s5_stay_idle", busy, 0);
    chk("s5_clr", clr_n, 0);
    clear_log(); pulse_start(); wait_done("s5");
    chk("s5_a0", aq[0], 0);
    chk("s5_count", count, 4);

    // single-entry log without clear
    start2 = 1; tick(); start2 = 0;
    for (n = 0; n < 20 && !done2; n++) tick();
    chk("s6_done", done2, 1);
    tick();
    chk("s6_nx", x2, 1);
    chk("s6_x0", last2, 38'h5);
    chk("s6_count", count2, 1);
    chk("s6_clr", clr2_n, 0);
    chk("s6_done_n", done2_n, 1);
    chk("s6_addr", addr2, 0);
    chk("re_clr_excl", both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/log_drain.md
LOG_DRAIN -- requirements
Module: log_drain

Interface
REQ-001 SHALL have parameter LOG_DEPTH, default 16, number of logger entries scanned (1..65535).
REQ-002 SHALL have parameter CLEAR_ON_DONE, default 1, pulse clr_ram after a completed drain when 1.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to drain the log; ignored unless idle.
REQ-006 abort  input  1  synchronous cancel of a drain in progress.
REQ-007 re  output  1  logger read enable.
REQ-008 rd_addr  output  16  logger read address.
REQ-009 rd_data  input  38  logger entry; valid the cycle after re.
REQ-010 clr_ram  output  1  logger clear strobe.
REQ-011 out_valid  output  1  entry available downstream.
REQ-012 out_ready  input  1  downstream accepts entry.
REQ-013 out_data  output  38  captured entry.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 done  output  1  one-cycle pulse when a drain ends (complete or aborted).
REQ-016 count  output  16  entries delivered in the last or current drain.

Function
REQ-017 FSM states SHALL be IDLE, READ, CAPT, SEND, CLEAR, FIN.
REQ-018 IDLE: start=1 -> READ; idx and count cleared to 0 on that edge.
REQ-019 READ: re=1, rd_addr=idx for exactly one cycle -> CAPT.
REQ-020 CAPT: rd_data registered into out_data; all-zero rd_data means empty slot -> CLEAR (entry not sent); else -> SEND.
REQ-021 SEND: out_valid=1, out_data stable until out_valid&out_ready; on transfer count+1, then idx==LOG_DEPTH-1 -> CLEAR, else idx+1 -> READ.
REQ-022 out_valid SHALL NOT depend combinationally on out_ready; out_ready while out_valid=0 has no effect.
REQ-023 CLEAR: clr_ram=1 for one cycle iff CLEAR_ON_DONE=1 -> FIN.
REQ-024 FIN: done=1 for one cycle -> IDLE.
REQ-025 Minimum latency per delivered entry SHALL be 3 cycles (READ, CAPT, SEND with out_ready=1).
REQ-026 idx SHALL never exceed LOG_DEPTH-1; no wrap-around to address 0 within a drain.
REQ-027 count SHALL saturate at 16'hFFFF and hold its value in IDLE until next start.
REQ-028 abort=1 in READ, CAPT or SEND -> FIN next edge; clr_ram SHALL NOT pulse; an in-flight out_valid drops without transfer; abort has priority over out_ready in the same cycle.
REQ-029 abort in IDLE, CLEAR or FIN SHALL be ignored; start while busy SHALL be ignored.
REQ-030 re and clr_ram SHALL never be high in the same cycle.

Reset
REQ-031 reset_n=0 SHALL asynchronously force IDLE, idx=0, count=0, out_data=0, and re, clr_ram, out_valid, busy, done all 0.
REQ-032 Reset mid-drain SHALL abandon the drain with no clr_ram pulse; first action after release requires a new start.

Structure
REQ-033 FSM state encoding, ENTRY_W=38 and ADDR_W=16 SHALL live in a shared package/defines file alongside the other logger constants.
REQ-034 One sub-module is natural: log_drain_ctr (idx counter with terminal-index flag and saturating count); everything else inline.
REQ-035 Instantiated beside logger in vrased, driving re, rd_addr and clr_ram, consuming rd_data.

Verification
REQ-036 LOG_DEPTH=4, entries 38'h1, 38'h2, 38'h3, 38'h4, out_ready=1: four transfers in order, count=4, one clr_ram pulse, done 1 cycle later, rd_addr sequence 0,1,2,3.
REQ-037 Entries 38'hA, 38'hB, then zero: two transfers, re issued for addr 0,1,2 only, count=2, clr_ram pulses.
REQ-038 out_ready held low 10 cycles on first entry 38'h3F_FFFF_FFFF: out_valid and out_data stable 10 cycles, no further re until transfer.
REQ-039 abort asserted during SEND of entry 1: no transfer, no clr_ram, done pulses, busy low next cycle, count=1.
REQ-040 reset_n low mid-READ: all outputs 0 immediately (asynchronous), start after release restarts at rd_addr=0.
REQ-041 CLEAR_ON_DONE=0, LOG_DEPTH=1, entry 38'h5: one transfer, clr_ram never asserted, done pulses.
